// File: rtl/range_sel_pkg.sv
// Shared types and helpers for the range selector: mode enum, lowest-set-bit
// encoder and multiple-hit detector over a match vector of up to MAX_CH bits.
package range_sel_pkg;

    typedef enum logic {
        SEL_PRIORITY = 1'b0,
        SEL_UNIQUE   = 1'b1
    } sel_mode_e;

    localparam int MAX_CH = 16;

    function automatic logic [3:0] onehot_lsb(input logic [MAX_CH-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if a second bit was set.
    function automatic logic popcnt_gt1(input logic [MAX_CH-1:0] m);
        return (m & (m - MAX_CH'(1))) != '0;
    endfunction

endpackage

// File: rtl/range_match.sv
// Inclusive unsigned range comparator for one channel; purely combinational.
// An inverted range (lo > hi) can never satisfy both compares, so it never matches.
module range_match #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] i_sel,
    input  logic [SEL_W-1:0] i_lo,
    input  logic [SEL_W-1:0] i_hi,
    output logic             o_match
);

    assign o_match = (i_lo <= i_sel) && (i_sel <= i_hi);

endmodule

// File: rtl/range_sel_unique.sv
// Registered N-channel range selector with runtime overlap/no-match reporting; RANGE_SEL_ASSERT_EN adds checks.
// Latency 1 from accept; in_ready = !out_valid || out_ready, result held until out_ready.
module range_sel_unique
    import range_sel_pkg::*;
#(
    parameter int N           = 4,
    parameter int SEL_W       = 3,
    parameter int DW          = 8,
    parameter int CNT_W       = 8,
    parameter int UNIQUE_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N*SEL_W-1:0]     lo_bounds,
    input  logic [N*SEL_W-1:0]     hi_bounds,
    input  logic [N*DW-1:0]        data_in,
    input  logic [DW-1:0]          default_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_hit,
    output logic                   err_overlap,
    output logic                   err_nomatch,
    output logic [CNT_W-1:0]       overlap_cnt,
    input  logic                   clr_err
);

    localparam int        IDX_W = $clog2(N);
    localparam sel_mode_e MODE  = (UNIQUE_MODE != 0) ? SEL_UNIQUE : SEL_PRIORITY;

    logic [N-1:0]      w_m;
    logic [MAX_CH-1:0] w_m_ext;
    logic [IDX_W-1:0]  w_idx;
    logic [DW-1:0]     w_sel_data;
    logic              w_hit;
    logic              w_ovl;
    logic              w_acc;

    logic              r_valid;
    logic [DW-1:0]     r_data;
    logic [IDX_W-1:0]  r_idx;
    logic              r_hit;
    logic              r_err_ovl;
    logic              r_err_nm;
    logic [CNT_W-1:0]  r_cnt;

    for (genvar g = 0; g < N; g++) begin : g_ch
        range_match #(.SEL_W(SEL_W)) u_match (
            .i_sel   (sel),
            .i_lo    (lo_bounds[g*SEL_W +: SEL_W]),
            .i_hi    (hi_bounds[g*SEL_W +: SEL_W]),
            .o_match (w_m[g])
        );
    end

    always_comb begin
        w_m_ext        = '0;
        w_m_ext[N-1:0] = w_m;
    end

    // Scanning down means the lowest matching channel is written last and wins.
    always_comb begin
        w_sel_data = default_data;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_m[i]) begin
                w_sel_data = data_in[i*DW +: DW];
            end
        end
    end

    assign w_idx    = IDX_W'(onehot_lsb(w_m_ext));
    assign w_hit    = |w_m;
    assign w_ovl    = (MODE == SEL_UNIQUE) && popcnt_gt1(w_m_ext);
    assign in_ready = !r_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_hit   <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_idx   <= w_hit ? w_idx : '0;
            r_hit   <= w_hit;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovl <= 1'b0;
            r_err_nm  <= 1'b0;
            r_cnt     <= '0;
        end else if (clr_err) begin
            r_err_ovl <= 1'b0;
            r_err_nm  <= 1'b0;
            r_cnt     <= '0;
        end else if (w_acc) begin
            if (!w_hit) begin
                r_err_nm <= 1'b1;
            end
            if (w_ovl) begin
                r_err_ovl <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_idx     = r_idx;
    assign out_hit     = r_hit;
    assign err_overlap = r_err_ovl;
    assign err_nomatch = r_err_nm;
    assign overlap_cnt = r_cnt;

`ifdef RANGE_SEL_ASSERT_EN
    always_ff @(posedge clk) begin
        if (rst_n && w_acc) begin
            a_no_overlap: assert (!w_ovl) else $warning("overlap sel=%0d m=%b", sel, w_m);
        end
    end

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(out_data));
`else
`endif

endmodule

// File: tb/tb_range_sel_unique.sv
module tb_range_sel_unique;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int DW = 8;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, out_ready, clr_err;
    logic [SW-1:0]    sel;
    logic [N*SW-1:0]  lo_b, hi_b;
    logic [N*DW-1:0]  din;
    logic [DW-1:0]    dflt;

    logic             ir  [2];
    logic             ov  [2];
    logic [DW-1:0]    od  [2];
    logic [1:0]       oi  [2];
    logic             oh  [2];
    logic             eo  [2];
    logic             en  [2];
    logic [CW-1:0]    oc  [2];

    int nvec  = 0;
    int nfail = 0;

    // Reference state per instance: 0 = unique mode, 1 = priority mode.
    bit mv [2];
    int md [2], mi [2], mh [2], mo [2], mn [2], mc [2];

    always #5 clk = ~clk;

    range_sel_unique #(.N(N), .SEL_W(SW), .DW(DW), .CNT_W(CW), .UNIQUE_MODE(1)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .sel(sel),
        .lo_bounds(lo_b), .hi_bounds(hi_b), .data_in(din), .default_data(dflt),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_idx(oi[0]),
        .out_hit(oh[0]), .err_overlap(eo[0]), .err_nomatch(en[0]), .overlap_cnt(oc[0]),
        .clr_err(clr_err));

    range_sel_unique #(.N(N), .SEL_W(SW), .DW(DW), .CNT_W(CW), .UNIQUE_MODE(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .sel(sel),
        .lo_bounds(lo_b), .hi_bounds(hi_b), .data_in(din), .default_data(dflt),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_idx(oi[1]),
        .out_hit(oh[1]), .err_overlap(eo[1]), .err_nomatch(en[1]), .overlap_cnt(oc[1]),
        .clr_err(clr_err));

    typedef struct packed {
        logic [SW-1:0]   sel;
        logic [N*SW-1:0] lo;
        logic [N*SW-1:0] hi;
        logic [N*DW-1:0] d;
        logic [DW-1:0]   dflt;
        logic [DW-1:0]   e_data;
        logic [1:0]      e_idx;
        logic            e_hit;
        logic            e_ovl;
        logic            e_nm;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; md[m] = 0; mi[m] = 0; mh[m] = 0; mo[m] = 0; mn[m] = 0; mc[m] = 0;
        end
    endtask

    // Entered at a negedge with inputs driven; returns at the following negedge.
    task automatic cycle();
        int  cnt, win;
        bit  acc;
        #1;
        cnt = 0;
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (int'(lo_b[i*SW +: SW]) <= int'(sel) && int'(sel) <= int'(hi_b[i*SW +: SW])) begin
                cnt++;
                if (win < 0) win = i;
            end
        end
        for (int m = 0; m < 2; m++)
            chk($sformatf("in_ready[%0d]", m), int'(ir[m]), int'(!mv[m] || out_ready));
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            acc = in_valid && (!mv[m] || out_ready);
            if (acc) begin
                mv[m] = 1;
                md[m] = (win >= 0) ? int'(din[win*DW +: DW]) : int'(dflt);
                mi[m] = (win >= 0) ? win : 0;
                mh[m] = (win >= 0) ? 1 : 0;
            end else if (out_ready) begin
                mv[m] = 0;
            end
            if (clr_err) begin
                mo[m] = 0; mn[m] = 0; mc[m] = 0;
            end else if (acc) begin
                if (cnt == 0) mn[m] = 1;
                if (m == 0 && cnt > 1) begin
                    mo[m] = 1;
                    if (mc[m] < (1 << CW) - 1) mc[m]++;
                end
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("out_valid[%0d]", m), int'(ov[m]), int'(mv[m]));
            if (mv[m]) begin
                chk($sformatf("out_data[%0d]", m), int'(od[m]), md[m]);
                chk($sformatf("out_idx[%0d]", m), int'(oi[m]), mi[m]);
                chk($sformatf("out_hit[%0d]", m), int'(oh[m]), mh[m]);
            end
            chk($sformatf("err_overlap[%0d]", m), int'(eo[m]), mo[m]);
            chk($sformatf("err_nomatch[%0d]", m), int'(en[m]), mn[m]);
            chk($sformatf("overlap_cnt[%0d]", m), int'(oc[m]), mc[m]);
        end
        @(negedge clk);
    endtask

    task automatic clear_flags();
        in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
    endtask

    vec_t vt [6];

    initial begin
        // ch2/ch3 inverted (lo=7, hi=0) so they never match unless a vector uses them.
        vt[0] = '{3'd4, {3'd7,3'd7,3'd0,3'd4}, {3'd0,3'd0,3'd4,3'd7}, {8'h00,8'h00,8'd3,8'd1}, 8'hAA, 8'd1,    2'd0, 1'b1, 1'b1, 1'b0};
        vt[1] = '{3'd0, {3'd7,3'd7,3'd0,3'd4}, {3'd0,3'd0,3'd4,3'd7}, {8'h00,8'h00,8'd3,8'd1}, 8'hAA, 8'd3,    2'd1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{3'd6, {3'd7,3'd7,3'd0,3'd4}, {3'd0,3'd0,3'd4,3'd7}, {8'h00,8'h00,8'd3,8'd1}, 8'hAA, 8'd1,    2'd0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{3'd3, {3'd7,3'd7,3'd0,3'd5}, {3'd0,3'd0,3'd2,3'd7}, {8'h00,8'h00,8'd3,8'd1}, 8'hAA, 8'hAA,   2'd0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{3'd3, {3'd3,3'd7,3'd7,3'd7}, {3'd3,3'd0,3'd0,3'd0}, {8'h5C,8'h00,8'h00,8'h00}, 8'hAA, 8'h5C, 2'd3, 1'b1, 1'b0, 1'b0};
        vt[5] = '{3'd7, {3'd7,3'd7,3'd0,3'd7}, {3'd0,3'd7,3'd7,3'd0}, {8'h00,8'h22,8'h11,8'h00}, 8'hAA, 8'h11, 2'd1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        sel = '0; lo_b = '0; hi_b = '0; din = '0; dflt = '0;
        model_reset();
        #12;
        for (int m = 0; m < 2; m++) begin
            chk("reset out_valid", int'(ov[m]), 0);
            chk("reset in_ready", int'(ir[m]), 1);
            chk("reset out_data", int'(od[m]), 0);
            chk("reset flags", int'({eo[m], en[m], oc[m]}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            clear_flags();
            sel = vt[k].sel; lo_b = vt[k].lo; hi_b = vt[k].hi; din = vt[k].d; dflt = vt[k].dflt;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("vec%0d data[%0d]", k, m), int'(od[m]), int'(vt[k].e_data));
                chk($sformatf("vec%0d idx[%0d]", k, m), int'(oi[m]), int'(vt[k].e_idx));
                chk($sformatf("vec%0d hit[%0d]", k, m), int'(oh[m]), int'(vt[k].e_hit));
                chk($sformatf("vec%0d nomatch[%0d]", k, m), int'(en[m]), int'(vt[k].e_nm));
            end
            chk($sformatf("vec%0d overlap_u", k), int'(eo[0]), int'(vt[k].e_ovl));
            chk($sformatf("vec%0d cnt_u", k), int'(oc[0]), int'(vt[k].e_ovl));
            chk($sformatf("vec%0d overlap_p", k), int'({eo[1], oc[1]}), 0);
        end

        // Backpressure: hold sel=0 result while new request and data wait.
        clear_flags();
        lo_b = vt[0].lo; hi_b = vt[0].hi; din = vt[0].d; sel = 3'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0; sel = 3'd6;
        for (int c = 0; c < 3; c++) begin
            din = {8'h00, 8'h00, 8'(8'h40 + c), 8'(8'h50 + c)};
            cycle();
            chk("bp in_ready", int'(ir[0]), 0);
            chk("bp out_data held", int'(od[0]), 3);
        end
        din = vt[0].d;
        out_ready = 1'b1;
        cycle();
        chk("bp drain+accept valid", int'(ov[0]), 1);
        chk("bp drain+accept data", int'(od[0]), 1);
        in_valid = 1'b0;
        cycle();

        // Saturation of the 2-bit counter, then clear beating a coincident overlap.
        clear_flags();
        sel = 3'd4; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        chk("sat overlap_cnt", int'(oc[0]), 3);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        chk("clr wins cnt", int'(oc[0]), 0);
        chk("clr wins flags", int'({eo[0], en[0]}), 0);
        in_valid = 1'b0;
        cycle();

        // Asynchronous reset while a result is held.
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd4;
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            chk("arst out_valid", int'(ov[m]), 0);
            chk("arst in_ready", int'(ir[m]), 1);
            chk("arst flags", int'({eo[m], oc[m]}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 400; c++) begin
            sel       = SW'($urandom_range(0, 7));
            lo_b      = (N*SW)'($urandom);
            hi_b      = (N*SW)'($urandom);
            din       = (N*DW)'($urandom);
            dflt      = DW'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
